// File: rtl/det_arb_pkg.sv
// Shared types and helpers for the determinant-engine arbiter.
package det_arb_pkg;

  localparam int ELEM_COUNT     = 9;
  localparam int ELEM_W_DEFAULT = 16;
  localparam int MAX_REQ        = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    ABORT = 3'd4
  } arb_state_e;

  // First requester at or after ptr, searching cyclically over n_req entries.
  function automatic logic [MAX_REQ-1:0] rr_pick_onehot(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input int                 n_req
  );
    logic [MAX_REQ-1:0] pick;
    int                 idx;
    pick = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n_req) begin
        idx = (int'(ptr) + k) % n_req;
        if (req[idx]) begin
          pick      = '0;
          pick[idx] = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/det_engine_arbiter_pick.sv
// Combinational round-robin selector: one-hot pick starting from the pointer.
module det_rr_pick
  import det_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic             any_req
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    req_ext             = '0;
    req_ext[N_REQ-1:0]  = req;
  end

  assign pick    = rr_pick_onehot(req_ext, 3'(ptr), N_REQ);
  assign grant   = pick[N_REQ-1:0];
  assign any_req = |pick;

endmodule

// File: rtl/det_engine_arbiter.sv
// Round-robin front end sharing one 3x3 determinant engine among N_REQ clients.
//   state | meaning
//   IDLE  | no owner; pick next requester once the engine is out of reset
//   LOAD  | stream the owner's 9 elements into the engine
//   WAIT  | wait for the engine result, bounded by WAIT_TIMEOUT
//   RESP  | one-cycle response strobe to the owner, advance pointer
//   ABORT | pulse engine reset after a dropped request or timeout
module det_engine_arbiter
  import det_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int ELEM_W       = ELEM_W_DEFAULT,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ELEM_W-1:0] req_mat_in,
  input  logic [N_REQ-1:0]        req_mat_valid,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [ELEM_W-1:0]       resp_det,
  output logic                    resp_overflow,
  output logic                    resp_err,
  output logic                    eng_rst_n,
  output logic [ELEM_W-1:0]       eng_mat_in,
  output logic                    eng_mat_valid,
  input  logic                    eng_mat_request,
  input  logic [ELEM_W-1:0]       eng_det,
  input  logic                    eng_det_valid,
  input  logic                    eng_overflow
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int WT_W  = $clog2(WAIT_TIMEOUT + 1);

  arb_state_e       state, state_nx;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] pick;
  logic             any_req;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] g_idx;
  logic [PTR_W-1:0] ptr_nx;
  logic [3:0]       elem_cnt;
  logic [WT_W-1:0]  wait_cnt;
  logic             rst_pend;
  logic             dropped;
  logic             owner_req;
  logic [ELEM_W-1:0] mat_sel;
  logic             mat_vld_sel;
  logic             accept;
  logic             last_elem;

  det_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) g_idx = PTR_W'(i);
    end
  end

  assign ptr_nx      = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
  assign owner_req   = |(req & grant_q);
  assign mat_sel     = req_mat_in[g_idx*ELEM_W +: ELEM_W];
  assign mat_vld_sel = req_mat_valid[g_idx];
  assign accept      = (state == LOAD) && eng_mat_request && mat_vld_sel;
  assign last_elem   = (elem_cnt == 4'(ELEM_COUNT - 1));

  // Engine stays in reset for the cycle after rst and during ABORT.
  assign eng_rst_n = ~rst & ~rst_pend & (state != ABORT);
  assign grant     = grant_q;

  always_comb begin
    state_nx      = state;
    req_ready     = '0;
    eng_mat_in    = '0;
    eng_mat_valid = 1'b0;
    resp_valid    = '0;
    unique case (state)
      IDLE: begin
        if (any_req && eng_rst_n) state_nx = LOAD;
      end
      LOAD: begin
        req_ready     = grant_q & {N_REQ{eng_mat_request}};
        eng_mat_in    = mat_sel;
        eng_mat_valid = mat_vld_sel & eng_mat_request;
        if (!owner_req)                state_nx = ABORT;
        else if (accept && last_elem)  state_nx = WAIT;
      end
      WAIT: begin
        if (!owner_req)          state_nx = ABORT;
        else if (eng_det_valid)  state_nx = RESP;
        else if (wait_cnt == '0) state_nx = ABORT;
      end
      ABORT: state_nx = RESP;
      RESP: begin
        if (!dropped) resp_valid = grant_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant_q       <= '0;
      ptr           <= '0;
      elem_cnt      <= '0;
      wait_cnt      <= '0;
      resp_det      <= '0;
      resp_overflow <= 1'b0;
      resp_err      <= 1'b0;
      rst_pend      <= 1'b1;
      dropped       <= 1'b0;
    end else begin
      state    <= state_nx;
      rst_pend <= 1'b0;
      unique case (state)
        IDLE: begin
          if (state_nx == LOAD) begin
            grant_q  <= pick;
            resp_err <= 1'b0;
            dropped  <= 1'b0;
            elem_cnt <= '0;
          end
        end
        LOAD: begin
          if (!owner_req) begin
            resp_err <= 1'b1;
            dropped  <= 1'b1;
            elem_cnt <= '0;
          end else if (accept) begin
            if (last_elem) begin
              elem_cnt <= '0;
              wait_cnt <= WT_W'(WAIT_TIMEOUT - 1);
            end else begin
              elem_cnt <= elem_cnt + 4'd1;
            end
          end
        end
        WAIT: begin
          if (!owner_req) begin
            resp_err <= 1'b1;
            dropped  <= 1'b1;
          end else if (eng_det_valid) begin
            resp_det      <= eng_det;
            resp_overflow <= eng_overflow;
          end else if (wait_cnt == '0) begin
            resp_err      <= 1'b1;
            resp_det      <= '0;
            resp_overflow <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          ptr     <= ptr_nx;
          grant_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/det_engine_arbiter.md
Name: det_engine_arbiter

Overview:
- Shares one 3x3 determinant engine between N_REQ requesters using round-robin arbitration.
- Streams the 9 row-major elements of the granted requester into the engine, then captures det/overflow and returns them to that requester as a one-cycle response.
- Owns the engine's active-low reset, so it can abort a stuck or abandoned transaction.
- Sits between requester clients and the matrix determinant engine.

Parameters:
N_REQ, 4, number of requesters (2..8)
ELEM_W, 16, element and determinant width
WAIT_TIMEOUT, 15, cycles allowed in WAIT for eng_det_valid before error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  N_REQ  per-requester transaction request; held high until resp_valid
req_mat_in  in  N_REQ*ELEM_W  per-requester element bus, requester i at bits [i*ELEM_W +: ELEM_W]
req_mat_valid  in  N_REQ  per-requester element valid
req_ready  out  N_REQ  element accepted this cycle (valid&ready)
grant  out  N_REQ  one-hot current owner
resp_valid  out  N_REQ  one-hot one-cycle response strobe
resp_det  out  ELEM_W  determinant for responding requester
resp_overflow  out  1  engine saturation flag
resp_err  out  1  transaction aborted or timed out
eng_rst_n  out  1  engine reset, active low
eng_mat_in  out  ELEM_W  element to engine
eng_mat_valid  out  1  element valid to engine
eng_mat_request  in  1  engine ready for elements
eng_det  in  ELEM_W  engine result
eng_det_valid  in  1  engine result valid
eng_overflow  in  1  engine overflow

Behaviour:
- Reset (rst high at posedge):
  - State goes to IDLE; grant, req_ready, resp_valid, resp_det, resp_overflow and resp_err all 0.
  - eng_rst_n is 0 during rst and for 1 cycle after; the RR pointer is set to 0; the element counter is set to 0.
- States: IDLE, LOAD, WAIT, RESP, ABORT.
- IDLE:
  - If any req is high and eng_rst_n=1, grant the first requester at or after the pointer, searching cyclically.
  - The grant is registered; go to LOAD.
- LOAD:
  - req_ready[g] = eng_mat_request & grant[g] (combinational from the registered grant).
  - eng_mat_in = req_mat_in[g] and eng_mat_valid = req_mat_valid[g] & eng_mat_request; both are 0 outside LOAD.
  - Each accepted element increments a 4-bit counter (0..8). On the 9th acceptance, clear the counter and go to WAIT.
- WAIT:
  - On eng_det_valid, register resp_det<=eng_det and resp_overflow<=eng_overflow, then go to RESP.
  - The engine normally responds 1 cycle after the 9th element.
  - A wait counter reaching WAIT_TIMEOUT sets resp_err<=1, resp_det<=0 and goes to ABORT.
- RESP:
  - resp_valid[g]=1 for exactly 1 cycle. resp_det, resp_overflow and resp_err are valid with resp_valid and held until the next response.
  - Pointer <= (g+1) mod N_REQ; grant cleared; go to IDLE.
- ABORT:
  - eng_rst_n=0 for 1 cycle, then RESP, which reports resp_err=1.
- Abort on request drop: if req[g] drops during LOAD or WAIT, go to ABORT with resp_err=1. No resp_valid is issued to a requester that has dropped req; the pointer still advances.
- Non-granted requesters: req_ready stays 0; their req_mat_valid is ignored.
- Simultaneous requests: strict round-robin, with no requester granted twice while another is waiting.
- resp_err is cleared at the start of each new grant.
- Latency, single requester with no stalls: 1 grant cycle + 9 load cycles + 1-2 wait cycles + 1 response cycle.
- Reset mid-operation: the transaction is discarded, no response is issued, and the engine is reset via eng_rst_n.
- Arithmetic: pointer wraps modulo N_REQ. The counter never exceeds 8, and an ELEM_COUNT-1 compare is used.

Decomposition:
- Package det_arb_pkg:
  - state enum {IDLE, LOAD, WAIT, RESP, ABORT}
  - ELEM_COUNT=9
  - ELEM_W default
  - function for the cyclic-priority one-hot pick
- Sub-module det_rr_pick: combinational round-robin selector.
  - Inputs: req vector, pointer. Outputs: one-hot grant, any_req.
  - Instantiated once.

Test Plan:
- Single requester 0 sends identity [1,0,0,0,1,0,0,0,1] -> 9 req_ready[0] pulses; resp_valid=0001 with resp_det=0x0001, resp_overflow=0, resp_err=0.
- req[0] and req[2] raised in the same cycle, each sending [2,0,0,0,3,0,0,0,4] -> requester 0 is served first, then 2; both get resp_det=0x0018; grant never overlaps.
- Requester 1 sends diag(100,100,100) -> resp_det=0x7FFF, resp_overflow=1; diag(-100,100,100) -> resp_det=0x8000, resp_overflow=1.
- Requester 3 drops req after 4 elements -> eng_rst_n low for 1 cycle; no resp_valid[3]; next requester is served normally with the correct det.
- Engine model never asserts det_valid -> after 15 WAIT cycles resp_err=1 with resp_valid on the owner, and eng_rst_n pulses.
- rst asserted during WAIT -> all outputs 0 next cycle; eng_rst_n low; the following transaction from requester 0 returns the correct result.
